// File: rtl/mem_access_ctrl_pkg.sv
// Shared definitions for the data-memory access controller.
//   state_t         : controller FSM states (IDLE, REQ, DONE)
//   ERR_RDATA       : load data returned when a request times out
//   TIMEOUT_DEFAULT : default cycle limit for the REQ state
package mem_access_ctrl_pkg;

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        REQ  = 2'd1,
        DONE = 2'd2
    } state_t;

    localparam logic [31:0] ERR_RDATA       = 32'hDEAD_BEEF;
    localparam int          TIMEOUT_DEFAULT = 255;

endpackage

// File: rtl/mem_access_ctrl.sv
// MEM-stage data-memory access controller. Turns a load/store held in the
// EX/MEM register into a single request/acknowledge transaction on the data
// memory port, stalling the front of the pipeline while it is outstanding.
//
// Ports:
//   clk, rst          : clock, asynchronous active-high reset
//   mem_read_i        : load request from EX/MEM
//   mem_write_i       : store request from EX/MEM (wins over mem_read_i)
//   addr_i, wdata_i   : byte address and store data from EX/MEM
//   stall_o           : freezes PC, IF/ID, ID/EX and EX/MEM (combinational)
//   rdata_o           : load data to MEM/WB, held until the next load completes
//   rdata_valid_o     : one-cycle pulse when rdata_o carries a completed load
//   misalign_o        : one-cycle pulse on a non-word-aligned access
//   bus_err_o         : one-cycle pulse when a request is aborted by timeout
//   dm_req_o, dm_we_o : memory request and write enable
//   dm_addr_o         : latched address to memory
//   dm_wdata_o        : latched store data to memory
//   dm_ack_i          : memory completion
//   dm_rdata_i        : memory read data
module mem_access_ctrl
    import mem_access_ctrl_pkg::*;
#(
    parameter int ADDR_W  = 32,
    parameter int DATA_W  = 32,
    parameter int TIMEOUT = TIMEOUT_DEFAULT
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              mem_read_i,
    input  logic              mem_write_i,
    input  logic [ADDR_W-1:0] addr_i,
    input  logic [DATA_W-1:0] wdata_i,
    output logic              stall_o,
    output logic [DATA_W-1:0] rdata_o,
    output logic              rdata_valid_o,
    output logic              misalign_o,
    output logic              bus_err_o,
    output logic              dm_req_o,
    output logic              dm_we_o,
    output logic [ADDR_W-1:0] dm_addr_o,
    output logic [DATA_W-1:0] dm_wdata_o,
    input  logic              dm_ack_i,
    input  logic [DATA_W-1:0] dm_rdata_i
);

    localparam logic [7:0]        TIMEOUT_LAST = 8'(TIMEOUT - 1);
    localparam logic [DATA_W-1:0] ERR_WORD     = DATA_W'(ERR_RDATA);

    state_t     state;
    logic [7:0] wait_cnt;
    logic       access;
    logic       aligned;

    assign access  = mem_read_i | mem_write_i;
    assign aligned = (addr_i[1:0] == 2'b00);

    // The stall must act in the same cycle the access appears, so it is
    // decoded from state and inputs. It is forced low while reset is held so
    // the pipeline is released the instant a transaction is killed.
    assign stall_o = !rst && (((state == IDLE) && access && aligned) || (state == REQ));

    // Single FSM block. The dm_* outputs double as the latched transaction
    // registers, so they stay constant for the whole REQ state. Pulse
    // outputs default low every cycle and are raised only on the transition
    // that produces them, so they are high for exactly the following cycle.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state         <= IDLE;
            wait_cnt      <= 8'd0;
            rdata_o       <= '0;
            rdata_valid_o <= 1'b0;
            misalign_o    <= 1'b0;
            bus_err_o     <= 1'b0;
            dm_req_o      <= 1'b0;
            dm_we_o       <= 1'b0;
            dm_addr_o     <= '0;
            dm_wdata_o    <= '0;
        end else begin
            rdata_valid_o <= 1'b0;
            misalign_o    <= 1'b0;
            bus_err_o     <= 1'b0;
            case (state)
                IDLE: begin
                    if (access) begin
                        if (aligned) begin
                            dm_addr_o  <= addr_i;
                            dm_wdata_o <= wdata_i;
                            dm_we_o    <= mem_write_i;
                            dm_req_o   <= 1'b1;
                            wait_cnt   <= 8'd0;
                            state      <= REQ;
                        end else begin
                            misalign_o <= 1'b1;
                        end
                    end
                end
                REQ: begin
                    // An acknowledge in the final allowed cycle still counts
                    // as a normal completion, so it is tested first.
                    if (dm_ack_i) begin
                        if (!dm_we_o) begin
                            rdata_o <= dm_rdata_i;
                        end
                        rdata_valid_o <= !dm_we_o;
                        dm_req_o      <= 1'b0;
                        state         <= DONE;
                    end else if (wait_cnt == TIMEOUT_LAST) begin
                        if (!dm_we_o) begin
                            rdata_o <= ERR_WORD;
                        end
                        rdata_valid_o <= !dm_we_o;
                        bus_err_o     <= 1'b1;
                        dm_req_o      <= 1'b0;
                        state         <= DONE;
                    end else begin
                        wait_cnt <= wait_cnt + 8'd1;
                    end
                end
                DONE: begin
                    // The finished instruction is still sitting in EX/MEM
                    // this cycle; ignore it and let the pipeline advance.
                    state <= IDLE;
                end
                default: begin
                    state <= IDLE;
                end
            endcase
        end
    end

endmodule

// File: tb/tb_mem_access_ctrl.sv
// Directed testbench for mem_access_ctrl (TIMEOUT=4). Inputs change on the
// falling edge and outputs are sampled 1 ns later, so registered outputs show
// the state after the previous rising edge and stall_o reflects the new inputs.
module tb_mem_access_ctrl;

    localparam int ADDR_W = 32;
    localparam int DATA_W = 32;

    logic              clk = 1'b0;
    logic              rst;
    logic              mem_read_i;
    logic              mem_write_i;
    logic [ADDR_W-1:0] addr_i;
    logic [DATA_W-1:0] wdata_i;
    logic              stall_o;
    logic [DATA_W-1:0] rdata_o;
    logic              rdata_valid_o;
    logic              misalign_o;
    logic              bus_err_o;
    logic              dm_req_o;
    logic              dm_we_o;
    logic [ADDR_W-1:0] dm_addr_o;
    logic [DATA_W-1:0] dm_wdata_o;
    logic              dm_ack_i;
    logic [DATA_W-1:0] dm_rdata_i;

    int n_cmp = 0;
    int n_err = 0;

    always #5 clk = ~clk;

    mem_access_ctrl #(
        .ADDR_W (ADDR_W),
        .DATA_W (DATA_W),
        .TIMEOUT(4)
    ) dut (
        .clk          (clk),
        .rst          (rst),
        .mem_read_i   (mem_read_i),
        .mem_write_i  (mem_write_i),
        .addr_i       (addr_i),
        .wdata_i      (wdata_i),
        .stall_o      (stall_o),
        .rdata_o      (rdata_o),
        .rdata_valid_o(rdata_valid_o),
        .misalign_o   (misalign_o),
        .bus_err_o    (bus_err_o),
        .dm_req_o     (dm_req_o),
        .dm_we_o      (dm_we_o),
        .dm_addr_o    (dm_addr_o),
        .dm_wdata_o   (dm_wdata_o),
        .dm_ack_i     (dm_ack_i),
        .dm_rdata_i   (dm_rdata_i)
    );

    // Releases the access request and returns to a quiet IDLE cycle.
    task automatic idle_cycle();
        @(negedge clk);
        mem_read_i  = 1'b0;
        mem_write_i = 1'b0;
        dm_ack_i    = 1'b0;
        #1;
    endtask

    task automatic test_reset();
        rst = 1'b1;
        mem_read_i = 1'b0; mem_write_i = 1'b0;
        addr_i = '0; wdata_i = '0; dm_ack_i = 1'b0; dm_rdata_i = '0;
        repeat (2) @(negedge clk);
        #1;
        n_cmp++;
        if ({stall_o, rdata_valid_o, misalign_o, bus_err_o, dm_req_o, dm_we_o} !== 6'b0) begin
            n_err++; $display("[TB] FAIL reset_ctrl: got %b want 000000",
                {stall_o, rdata_valid_o, misalign_o, bus_err_o, dm_req_o, dm_we_o});
        end
        n_cmp++;
        if ({rdata_o, dm_addr_o, dm_wdata_o} !== 96'h0) begin
            n_err++; $display("[TB] FAIL reset_data: got %h %h %h want 0", rdata_o, dm_addr_o, dm_wdata_o);
        end
        @(negedge clk);
        rst = 1'b0;
    endtask

    // Load at 0x100 acknowledged on the first REQ cycle.
    task automatic test_load();
        int stalls = 0;
        for (int c = 0; c < 3; c++) begin
            @(negedge clk);
            mem_read_i = 1'b1; addr_i = 32'h100;
            dm_ack_i   = (c == 1);
            dm_rdata_i = 32'h1234_5678;
            #1;
            if (stall_o) stalls++;
            if (c == 1) begin
                n_cmp++;
                if ({dm_req_o, dm_we_o} !== 2'b10 || dm_addr_o !== 32'h100) begin
                    n_err++; $display("[TB] FAIL load_req: got req/we %b addr %h want 10 100",
                        {dm_req_o, dm_we_o}, dm_addr_o);
                end
            end
        end
        n_cmp++;
        if (stalls != 2) begin
            n_err++; $display("[TB] FAIL load_stalls: got %0d want 2", stalls);
        end
        n_cmp++;
        if (rdata_valid_o !== 1'b1 || rdata_o !== 32'h1234_5678 || dm_req_o !== 1'b0) begin
            n_err++; $display("[TB] FAIL load_done: got valid %b rdata %h req %b want 1 12345678 0",
                rdata_valid_o, rdata_o, dm_req_o);
        end
        idle_cycle();
        n_cmp++;
        if (rdata_valid_o !== 1'b0 || stall_o !== 1'b0) begin
            n_err++; $display("[TB] FAIL load_after: got valid %b stall %b want 0 0", rdata_valid_o, stall_o);
        end
    endtask

    // Store at 0x200 acknowledged on the fourth REQ cycle: IDLE + 4 REQ stall.
    task automatic test_store();
        int stalls = 0;
        int reqs   = 0;
        int stable = 0;
        for (int c = 0; c < 6; c++) begin
            @(negedge clk);
            mem_write_i = 1'b1; addr_i = 32'h200; wdata_i = 32'hCAFE_F00D;
            dm_ack_i    = (c == 4);
            #1;
            if (stall_o) stalls++;
            if (dm_req_o) begin
                reqs++;
                if (dm_we_o === 1'b1 && dm_addr_o === 32'h200 && dm_wdata_o === 32'hCAFE_F00D) stable++;
            end
        end
        n_cmp++;
        if (stalls != 5) begin
            n_err++; $display("[TB] FAIL store_stalls: got %0d want 5", stalls);
        end
        n_cmp++;
        if (reqs != 4 || stable != 4) begin
            n_err++; $display("[TB] FAIL store_req: got req %0d stable %0d want 4 4", reqs, stable);
        end
        n_cmp++;
        if (rdata_valid_o !== 1'b0 || bus_err_o !== 1'b0 || rdata_o !== 32'h1234_5678) begin
            n_err++; $display("[TB] FAIL store_done: got valid %b err %b rdata %h want 0 0 12345678",
                rdata_valid_o, bus_err_o, rdata_o);
        end
        idle_cycle();
    endtask

    // Misaligned load at 0x102, with a stray ack that must be ignored.
    task automatic test_misalign();
        int reqs = 0;
        int stalls = 0;
        @(negedge clk);
        mem_read_i = 1'b1; addr_i = 32'h102;
        #1;
        if (stall_o) stalls++;
        if (dm_req_o) reqs++;
        @(negedge clk);
        mem_read_i = 1'b0; dm_ack_i = 1'b1; dm_rdata_i = 32'h5555_5555;
        #1;
        if (stall_o) stalls++;
        if (dm_req_o) reqs++;
        n_cmp++;
        if (misalign_o !== 1'b1) begin
            n_err++; $display("[TB] FAIL misalign_pulse: got %b want 1", misalign_o);
        end
        idle_cycle();
        if (dm_req_o) reqs++;
        n_cmp++;
        if (misalign_o !== 1'b0 || reqs != 0 || stalls != 0 || rdata_o !== 32'h1234_5678) begin
            n_err++; $display("[TB] FAIL misalign_quiet: got mis %b req %0d stall %0d rdata %h want 0 0 0 12345678",
                misalign_o, reqs, stalls, rdata_o);
        end
    endtask

    // Load with no ack: 4 REQ cycles then abort with the error word.
    task automatic test_timeout();
        int reqs = 0;
        for (int c = 0; c < 6; c++) begin
            @(negedge clk);
            mem_read_i = 1'b1; addr_i = 32'h300; dm_ack_i = 1'b0;
            #1;
            if (dm_req_o) reqs++;
        end
        n_cmp++;
        if (reqs != 4) begin
            n_err++; $display("[TB] FAIL timeout_reqs: got %0d want 4", reqs);
        end
        n_cmp++;
        if (bus_err_o !== 1'b1 || rdata_valid_o !== 1'b1 || rdata_o !== 32'hDEAD_BEEF || stall_o !== 1'b0) begin
            n_err++; $display("[TB] FAIL timeout_done: got err %b valid %b rdata %h stall %b want 1 1 deadbeef 0",
                bus_err_o, rdata_valid_o, rdata_o, stall_o);
        end
        idle_cycle();
        n_cmp++;
        if (bus_err_o !== 1'b0) begin
            n_err++; $display("[TB] FAIL timeout_pulse: got %b want 0", bus_err_o);
        end
    endtask

    // Ack arriving in the last allowed REQ cycle completes normally.
    task automatic test_ack_at_timeout();
        for (int c = 0; c < 6; c++) begin
            @(negedge clk);
            mem_read_i = 1'b1; addr_i = 32'h304;
            dm_ack_i   = (c == 4);
            dm_rdata_i = 32'hA5A5_5A5A;
            #1;
        end
        n_cmp++;
        if (bus_err_o !== 1'b0 || rdata_valid_o !== 1'b1 || rdata_o !== 32'hA5A5_5A5A) begin
            n_err++; $display("[TB] FAIL ack_at_timeout: got err %b valid %b rdata %h want 0 1 a5a55a5a",
                bus_err_o, rdata_valid_o, rdata_o);
        end
        idle_cycle();
    endtask

    // Read and write together behave as a store.
    task automatic test_read_write();
        for (int c = 0; c < 3; c++) begin
            @(negedge clk);
            mem_read_i = 1'b1; mem_write_i = 1'b1;
            addr_i = 32'h400; wdata_i = 32'h1111_2222;
            dm_ack_i = (c == 1); dm_rdata_i = 32'h7777_7777;
            #1;
            if (c == 1) begin
                n_cmp++;
                if ({dm_req_o, dm_we_o} !== 2'b11 || dm_wdata_o !== 32'h1111_2222) begin
                    n_err++; $display("[TB] FAIL rw_req: got req/we %b wdata %h want 11 11112222",
                        {dm_req_o, dm_we_o}, dm_wdata_o);
                end
            end
        end
        n_cmp++;
        if (rdata_valid_o !== 1'b0 || rdata_o !== 32'hA5A5_5A5A) begin
            n_err++; $display("[TB] FAIL rw_done: got valid %b rdata %h want 0 a5a55a5a", rdata_valid_o, rdata_o);
        end
        idle_cycle();
    endtask

    // Reset asserted in the middle of REQ, then a fresh load.
    task automatic test_reset_mid();
        @(negedge clk);
        mem_read_i = 1'b1; addr_i = 32'h500; dm_ack_i = 1'b0;
        @(negedge clk);
        #1;
        n_cmp++;
        if (dm_req_o !== 1'b1) begin
            n_err++; $display("[TB] FAIL rstmid_pre: got req %b want 1", dm_req_o);
        end
        #2;
        rst = 1'b1;
        #1;
        n_cmp++;
        if (dm_req_o !== 1'b0 || stall_o !== 1'b0 || rdata_o !== 32'h0 || dm_addr_o !== 32'h0) begin
            n_err++; $display("[TB] FAIL rstmid_kill: got req %b stall %b rdata %h addr %h want 0 0 0 0",
                dm_req_o, stall_o, rdata_o, dm_addr_o);
        end
        @(negedge clk);
        rst = 1'b0; mem_read_i = 1'b0;
        for (int c = 0; c < 3; c++) begin
            @(negedge clk);
            mem_read_i = 1'b1; addr_i = 32'h104;
            dm_ack_i   = (c == 1); dm_rdata_i = 32'h0BAD_F00D;
            #1;
        end
        n_cmp++;
        if (rdata_valid_o !== 1'b1 || rdata_o !== 32'h0BAD_F00D || bus_err_o !== 1'b0) begin
            n_err++; $display("[TB] FAIL rstmid_after: got valid %b rdata %h err %b want 1 0badf00d 0",
                rdata_valid_o, rdata_o, bus_err_o);
        end
        idle_cycle();
    endtask

    initial begin
        $display("[TB] start");
        test_reset();
        test_load();
        test_store();
        test_misalign();
        test_timeout();
        test_ack_at_timeout();
        test_read_write();
        test_reset_mid();
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end

endmodule
